// File: rtl/bc_operand_chain_queue_if.sv
// Broadcast operand queue bus: upstream element, per-consumer handshakes and next-lane forwarding.
// Latency: none, signal bundle only.
// Backpressure: carries bc_ready_o (upstream retire), cons_ready_i (local units) and bc_ready_i (next lane).
interface bc_operand_chain_queue_if #(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned Depth       = 2,
    parameter int unsigned NrConsumers = 2
);
    localparam int unsigned UsageWidth = $clog2(Depth + 1);

    // Control
    logic                   flush_i;

    // Upstream (previous lane or broadcast buffer)
    logic                   bc_valid_i;
    logic [DataWidth-1:0]   bc_data_i;
    logic                   bc_ready_o;

    // Downstream (next lane)
    logic                   bc_valid_o;
    logic [DataWidth-1:0]   bc_data_o;
    logic                   bc_ready_i;

    // Local consumers
    logic [NrConsumers-1:0] cons_en_i;
    logic [NrConsumers-1:0] cons_valid_o;
    logic [DataWidth-1:0]   cons_data_o;
    logic [NrConsumers-1:0] cons_ready_i;

    // Status
    logic [UsageWidth-1:0]  usage_o;
    logic [31:0]            perf_stall_cnt_o;

    // Environment side: drives the queue inputs, observes its outputs.
    modport master (
        output flush_i, bc_valid_i, bc_data_i, bc_ready_i, cons_en_i, cons_ready_i,
        input  bc_ready_o, bc_valid_o, bc_data_o, cons_valid_o, cons_data_o,
               usage_o, perf_stall_cnt_o
    );

    // Queue side.
    modport slave (
        input  flush_i, bc_valid_i, bc_data_i, bc_ready_i, cons_en_i, cons_ready_i,
        output bc_ready_o, bc_valid_o, bc_data_o, cons_valid_o, cons_data_o,
               usage_o, perf_stall_cnt_o
    );
endinterface

// File: rtl/bc_operand_chain_queue.sv
// Broadcast operand queue: offers each upstream element to local consumers and forwards it through a FIFO.
// Latency: consumers see the element combinationally; the next lane sees it one cycle after retire.
// Backpressure: element retires once all enabled consumers took it and the FIFO is not full (BC_OPQUEUE_PERF_EN adds a stall counter).
module bc_operand_chain_queue #(
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned Depth       = 2,
    parameter int unsigned NrConsumers = 2,
    parameter bit          IsLastLane  = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    bc_operand_chain_queue_if.slave      bus
);

    localparam int unsigned UsageWidth = $clog2(Depth + 1);

    // Per-consumer tracking of who already took the element currently held upstream.
    logic [NrConsumers-1:0] taken_q, taken_d;
    logic [NrConsumers-1:0] cons_vld;
    logic [NrConsumers-1:0] cons_hs;
    logic [NrConsumers-1:0] cons_done;

    logic fifo_full;
    logic space;
    logic retire;

    // Offer the element to each enabled consumer that has not taken it yet; nothing is offered during flush.
    always_comb begin
        cons_vld  = bus.cons_en_i & ~taken_q & {NrConsumers{bus.bc_valid_i & ~bus.flush_i}};
        cons_hs   = cons_vld & bus.cons_ready_i;
        cons_done = ~bus.cons_en_i | taken_q | cons_hs;
    end

    // The full check deliberately ignores a same-cycle pop so bc_ready_i never reaches bc_ready_o,
    // which would otherwise build a combinational path along the whole lane chain.
    assign space  = IsLastLane | ~fifo_full;
    assign retire = bus.bc_valid_i & (&cons_done) & space & ~bus.flush_i;

    assign bus.bc_ready_o   = retire;
    assign bus.cons_valid_o = cons_vld;
    assign bus.cons_data_o  = bus.bc_data_i;

    // Remember handshakes until the element retires, so no consumer is offered it twice.
    always_comb begin
        taken_d = taken_q;
        if (bus.flush_i || retire) begin
            taken_d = '0;
        end else begin
            taken_d = taken_q | cons_hs;
        end
    end

    // Taken-state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            taken_q <= '0;
        end else begin
            taken_q <= taken_d;
        end
    end

    if (!IsLastLane) begin : g_fifo
        localparam int unsigned          PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
        localparam logic [PtrWidth-1:0]  LastPtr  = PtrWidth'(Depth - 1);
        localparam logic [UsageWidth-1:0] FullCnt = UsageWidth'(Depth);

        logic [DataWidth-1:0]  mem_q [Depth];
        logic [DataWidth-1:0]  mem_d [Depth];
        logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
        logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
        logic [UsageWidth-1:0] usage_q, usage_d;
        logic                  push;
        logic                  pop;

        assign fifo_full = (usage_q == FullCnt);
        assign push      = retire;
        assign pop       = (usage_q != '0) & bus.bc_ready_i;

        // Pointer/occupancy update; flush discards contents but a pop in the same cycle still happens.
        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            usage_d  = usage_q;
            if (push) begin
                mem_d[wr_ptr_q] = bus.bc_data_i;
                wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   usage_d = usage_q + UsageWidth'(1);
                2'b01:   usage_d = usage_q - UsageWidth'(1);
                default: usage_d = usage_q;
            endcase
            if (bus.flush_i) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                usage_d  = '0;
            end
        end

        // FIFO storage and pointer registers.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    mem_q[i] <= '0;
                end
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                usage_q  <= '0;
            end else begin
                mem_q    <= mem_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                usage_q  <= usage_d;
            end
        end

        assign bus.bc_valid_o = (usage_q != '0);
        assign bus.bc_data_o  = mem_q[rd_ptr_q];
        assign bus.usage_o    = usage_q;
    end else begin : g_last
        // End of chain: nothing to forward, retire depends on the local consumers only.
        assign fifo_full      = 1'b0;
        assign bus.bc_valid_o = 1'b0;
        assign bus.bc_data_o  = '0;
        assign bus.usage_o    = '0;
    end

`ifdef BC_OPQUEUE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Count cycles an element waits upstream; saturate rather than wrap.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.bc_valid_i && !retire && !bus.flush_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.perf_stall_cnt_o = stall_cnt_q;
`else
    assign bus.perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bc_operand_chain_queue.sv
// Bench for the broadcast operand queue: directed scenarios plus randomized traffic.
// Expected behaviour comes from an element-level model (who received what, queue of retired elements).
// A negedge monitor compares every cycle; directed sections add targeted checks.
module tb_bc_operand_chain_queue;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int NC    = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bc_operand_chain_queue_if #(.DataWidth(DW), .Depth(DEPTH), .NrConsumers(NC)) bus ();
    bc_operand_chain_queue_if #(.DataWidth(DW), .Depth(DEPTH), .NrConsumers(NC)) ll_bus ();

    bc_operand_chain_queue #(.DataWidth(DW), .Depth(DEPTH), .NrConsumers(NC), .IsLastLane(1'b0)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    bc_operand_chain_queue #(.DataWidth(DW), .Depth(DEPTH), .NrConsumers(NC), .IsLastLane(1'b1)) dut_ll (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (ll_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int            m_cnt;            // elements retired but not yet taken by the next lane
    logic [NC-1:0] m_got;            // consumers that already received the pending element
    logic [63:0]   fwd_q[$];         // retired elements in forwarding order
    longint        m_stall;
    int            hs_total[NC];
    logic [63:0]   cur_data;

    // Monitor/scoreboard: compare at negedge, then advance the model to the next edge.
    always @(negedge clk) begin
        logic [NC-1:0] exp_cv;
        logic [NC-1:0] hs;
        logic          exp_ret;
        logic          pop;
        logic [63:0]   exp_perf;
        if (!rst_n) begin
            m_cnt   = 0;
            m_got   = '0;
            m_stall = 0;
            fwd_q.delete();
        end else begin
            exp_cv  = (bus.bc_valid_i && !bus.flush_i) ? (bus.cons_en_i & ~m_got) : '0;
            hs      = exp_cv & bus.cons_ready_i;
            exp_ret = bus.bc_valid_i && !bus.flush_i && (m_cnt < DEPTH)
                      && ((bus.cons_en_i & ~(m_got | hs)) == '0);
            pop     = (m_cnt > 0) && bus.bc_ready_i;
`ifdef BC_OPQUEUE_PERF_EN
            exp_perf = 64'(m_stall);
`else
            exp_perf = 64'd0;
`endif
            chk("cons_valid_o", 64'(bus.cons_valid_o), 64'(exp_cv));
            chk("bc_ready_o", 64'(bus.bc_ready_o), 64'(exp_ret));
            chk("bc_valid_o", 64'(bus.bc_valid_o), 64'(m_cnt > 0));
            chk("usage_o", 64'(bus.usage_o), 64'(m_cnt));
            chk("perf_stall_cnt_o", 64'(bus.perf_stall_cnt_o), exp_perf);
            if (hs != '0) chk("cons_data_o", bus.cons_data_o, cur_data);
            if (pop) begin
                if (fwd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fwd_underflow: pop with nothing expected at %0t", $time);
                end else begin
                    chk("bc_data_o", bus.bc_data_o, fwd_q.pop_front());
                end
            end
            for (int k = 0; k < NC; k++) if (hs[k]) hs_total[k]++;
            if (bus.bc_valid_i && !exp_ret && !bus.flush_i && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (bus.flush_i) begin
                m_cnt = 0;
                m_got = '0;
                fwd_q.delete();
            end else begin
                if (exp_ret) begin
                    fwd_q.push_back(cur_data);
                    m_got = '0;
                end else begin
                    m_got = m_got | hs;
                end
                m_cnt = m_cnt + (exp_ret ? 1 : 0) - (pop ? 1 : 0);
            end
        end
    end

    // One cycle of stimulus: drive at posedge+1, report retire and consumer valids seen at negedge.
    task automatic cyc(input logic v, input logic [63:0] d, input logic [1:0] en,
                       input logic [1:0] cr, input logic br, input logic fl,
                       output logic ret, output logic [1:0] cv);
        bus.bc_valid_i   = v;
        bus.bc_data_i    = d;
        bus.cons_en_i    = en;
        bus.cons_ready_i = cr;
        bus.bc_ready_i   = br;
        bus.flush_i      = fl;
        cur_data         = d;
        @(negedge clk);
        ret = bus.bc_ready_o;
        cv  = bus.cons_valid_o;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic r;
        logic [1:0] c;
        for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 2'b00, 2'b00, 1'b1, 1'b0, r, c);
    endtask

    task automatic run_random(input int cycles);
        logic       v   = 1'b0;
        logic [63:0] d  = '0;
        logic [1:0] en  = '0;
        logic       ret = 1'b0;
        logic [1:0] cv;
        for (int c = 0; c < cycles; c++) begin
            if (v && ret) v = 1'b0;
            if (!v && $urandom_range(0, 99) < 70) begin
                v  = 1'b1;
                d  = {$urandom, $urandom};
                en = 2'($urandom_range(0, 3));
            end
            cyc(v, d, en, 2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 60),
                ($urandom_range(0, 99) < 3), ret, cv);
        end
    endtask

    initial begin
        logic       r;
        logic [1:0] cv;
        int         h0, h1;

        bus.flush_i = 0; bus.bc_valid_i = 0; bus.bc_data_i = '0; bus.bc_ready_i = 1;
        bus.cons_en_i = '0; bus.cons_ready_i = '0;
        ll_bus.flush_i = 0; ll_bus.bc_valid_i = 0; ll_bus.bc_data_i = '0; ll_bus.bc_ready_i = 1;
        ll_bus.cons_en_i = '0; ll_bus.cons_ready_i = '0;
        cur_data = '0;
        for (int k = 0; k < NC; k++) hs_total[k] = 0;

        // Reset values
        #12;
        chk("rst_bc_valid_o", 64'(bus.bc_valid_o), 64'd0);
        chk("rst_bc_data_o", bus.bc_data_o, 64'd0);
        chk("rst_bc_ready_o", 64'(bus.bc_ready_o), 64'd0);
        chk("rst_cons_valid_o", 64'(bus.cons_valid_o), 64'd0);
        chk("rst_usage_o", 64'(bus.usage_o), 64'd0);
        chk("rst_perf", 64'(bus.perf_stall_cnt_o), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Five stall cycles, then retire
        for (int i = 0; i < 5; i++) cyc(1'b1, 64'h77, 2'b11, 2'b00, 1'b1, 1'b0, r, cv);
`ifdef BC_OPQUEUE_PERF_EN
        chk("perf_after_5_stalls", 64'(bus.perf_stall_cnt_o), 64'd5);
`else
        chk("perf_disabled", 64'(bus.perf_stall_cnt_o), 64'd0);
`endif
        cyc(1'b1, 64'h77, 2'b11, 2'b11, 1'b1, 1'b0, r, cv);
        chk("perf_release_ret", 64'(r), 64'd1);
        idle(2);

        // Full-rate stream 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 64'(32'h10 + i), 2'b11, 2'b11, 1'b1, 1'b0, r, cv);
            chk("stream_ret", 64'(r), 64'd1);
        end
        idle(2);

        // Consumers ready at different times
        h0 = hs_total[0]; h1 = hs_total[1];
        cyc(1'b1, 64'hAA, 2'b11, 2'b01, 1'b1, 1'b0, r, cv);
        chk("aa_c0_ret", 64'(r), 64'd0);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 64'hAA, 2'b11, 2'b00, 1'b1, 1'b0, r, cv);
            chk("aa_wait_cv", 64'(cv), 64'b10);
        end
        cyc(1'b1, 64'hAA, 2'b11, 2'b10, 1'b1, 1'b0, r, cv);
        chk("aa_retire_c3", 64'(r), 64'd1);
        chk("aa_hs0", 64'(hs_total[0] - h0), 64'd1);
        chk("aa_hs1", 64'(hs_total[1] - h1), 64'd1);
        idle(2);

        // Next lane stalled: third element blocked although consumers took it
        cyc(1'b1, 64'h31, 2'b11, 2'b11, 1'b0, 1'b0, r, cv);
        cyc(1'b1, 64'h32, 2'b11, 2'b11, 1'b0, 1'b0, r, cv);
        h0 = hs_total[0]; h1 = hs_total[1];
        cyc(1'b1, 64'h33, 2'b11, 2'b11, 1'b0, 1'b0, r, cv);
        chk("full_block_ret", 64'(r), 64'd0);
        chk("full_usage", 64'(bus.usage_o), 64'd2);
        cyc(1'b1, 64'h33, 2'b11, 2'b11, 1'b1, 1'b0, r, cv);
        chk("full_pop_no_push", 64'(r), 64'd0);
        chk("full_no_reoffer", 64'(cv), 64'd0);
        cyc(1'b1, 64'h33, 2'b11, 2'b11, 1'b1, 1'b0, r, cv);
        chk("full_late_ret", 64'(r), 64'd1);
        chk("full_hs0", 64'(hs_total[0] - h0), 64'd1);
        chk("full_hs1", 64'(hs_total[1] - h1), 64'd1);
        idle(3);

        // Flush with a full FIFO and consumer 0 already served
        cyc(1'b1, 64'h41, 2'b11, 2'b11, 1'b0, 1'b0, r, cv);
        cyc(1'b1, 64'h42, 2'b11, 2'b11, 1'b0, 1'b0, r, cv);
        cyc(1'b1, 64'h43, 2'b11, 2'b01, 1'b0, 1'b0, r, cv);
        cyc(1'b1, 64'h43, 2'b11, 2'b00, 1'b0, 1'b1, r, cv);
        chk("flush_ret", 64'(r), 64'd0);
        chk("flush_cv", 64'(cv), 64'd0);
        chk("flush_usage", 64'(bus.usage_o), 64'd0);
        chk("flush_bc_valid_o", 64'(bus.bc_valid_o), 64'd0);
        cyc(1'b1, 64'h43, 2'b11, 2'b00, 1'b0, 1'b0, r, cv);
        chk("flush_reoffer", 64'(cv), 64'b11);
        cyc(1'b1, 64'h43, 2'b11, 2'b11, 1'b1, 1'b0, r, cv);
        chk("flush_after_ret", 64'(r), 64'd1);
        idle(3);

        // Asynchronous reset mid-cycle with the FIFO holding data
        cyc(1'b1, 64'h51, 2'b00, 2'b00, 1'b0, 1'b0, r, cv);
        cyc(1'b1, 64'h52, 2'b00, 2'b00, 1'b0, 1'b0, r, cv);
        bus.bc_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_usage", 64'(bus.usage_o), 64'd0);
        chk("arst_bc_valid_o", 64'(bus.bc_valid_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic
        run_random(3000);
        idle(4);

        // Last lane: retire on consumer handshake only, never forward
        ll_bus.bc_valid_i = 1'b1; ll_bus.bc_data_i = 64'h55; ll_bus.cons_en_i = 2'b01;
        ll_bus.cons_ready_i = 2'b00;
        @(negedge clk);
        chk("ll_wait_ret", 64'(ll_bus.bc_ready_o), 64'd0);
        chk("ll_wait_cv", 64'(ll_bus.cons_valid_o), 64'b01);
        chk("ll_cons_data", ll_bus.cons_data_o, 64'h55);
        @(posedge clk); #1;
        ll_bus.cons_ready_i = 2'b01;
        @(negedge clk);
        chk("ll_ret", 64'(ll_bus.bc_ready_o), 64'd1);
        chk("ll_bc_valid_o", 64'(ll_bus.bc_valid_o), 64'd0);
        @(posedge clk); #1;
        ll_bus.bc_valid_i = 1'b0; ll_bus.cons_ready_i = 2'b00;
        @(negedge clk);
        chk("ll_bc_valid_o_after", 64'(ll_bus.bc_valid_o), 64'd0);
        chk("ll_usage", 64'(ll_bus.usage_o), 64'd0);
        chk("ll_bc_data_o", ll_bus.bc_data_o, 64'd0);
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
